multiplier_share_arbiter: RTL and testbench

//   Round-robin scheduler that shares one constant-time sequential shift-add multiplier

---
 rtl/multiplier_share_arbiter_if.sv | 49 ++++
 rtl/multiplier_share_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_multiplier_share_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_share_arbiter_if.sv
// Requester and multiplier bundle for multiplier_share_arbiter.
// slave is the arbiter's view; master is the environment's view.
interface multiplier_share_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_t;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       op_t;
    logic [NREQ-1:0]       gnt;
    logic                  gnt_t;
    logic [NREQ-1:0]       done;
    logic                  done_t;
    logic [2*WIDTH-1:0]    result;
    logic                  result_t;
    logic                  err;
    logic                  err_t;
    logic                  mul_start;
    logic                  mul_start_t;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_op_t;
    logic                  mul_productDone;
    logic                  mul_productDone_t;
    logic [2*WIDTH-1:0]    mul_product;
    logic                  mul_product_t;

    modport slave (
        input  req, req_t, op_a, op_b, op_t,
        input  mul_productDone, mul_productDone_t,
        input  mul_product, mul_product_t,
        output gnt, gnt_t, done, done_t,
        output result, result_t, err, err_t,
        output mul_start, mul_start_t,
        output mul_a, mul_b, mul_op_t
    );

    modport master (
        output req, req_t, op_a, op_b, op_t,
        output mul_productDone, mul_productDone_t,
        output mul_product, mul_product_t,
        input  gnt, gnt_t, done, done_t,
        input  result, result_t, err, err_t,
        input  mul_start, mul_start_t,
        input  mul_a, mul_b, mul_op_t
    );
endinterface

// File: rtl/multiplier_share_arbiter.sv
// Round-robin sharing of one sequential multiplier between NREQ requesters,
// with a completion watchdog and taint bits carried on every output.
module multiplier_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 2*WIDTH+6
) (
    input logic                     clk,
    input logic                     rst,
    multiplier_share_arbiter_if.slave io_bus
);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WDW = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_ptr, w_ptr_nxt;
    logic [PW-1:0]      r_owner, w_owner_nxt;
    logic [WDW-1:0]     r_wd, w_wd_nxt;
    logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
    logic               r_gnt_t, w_gnt_t_nxt;
    logic [NREQ-1:0]    r_done, w_done_nxt;
    logic               r_done_t, w_done_t_nxt;
    logic [2*WIDTH-1:0] r_result, w_result_nxt;
    logic               r_result_t, w_result_t_nxt;
    logic               r_err, w_err_nxt;
    logic               r_err_t, w_err_t_nxt;
    logic               r_start, w_start_nxt;
    logic               r_start_t, w_start_t_nxt;
    logic [WIDTH-1:0]   r_mul_a, w_mul_a_nxt;
    logic [WIDTH-1:0]   r_mul_b, w_mul_b_nxt;
    logic               r_mul_op_t, w_mul_op_t_nxt;

    logic [PW-1:0]      w_win;
    logic [PW-1:0]      w_idx;
    logic [NREQ-1:0]    w_win_oh;
    logic [NREQ-1:0]    w_own_oh;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic               w_opt;
    logic               w_res_t;

    // Scan downward so the lowest offset from ptr+1 is written last and wins.
    always_comb begin
        int j;
        w_win = '0;
        w_idx = '0;
        j     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            w_idx = PW'(j);
            if (io_bus.req[w_idx]) w_win = w_idx;
        end
    end

    always_comb begin
        w_a      = '0;
        w_b      = '0;
        w_opt    = 1'b0;
        w_win_oh = '0;
        w_own_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == w_win) begin
                w_a         = io_bus.op_a[i*WIDTH +: WIDTH];
                w_b         = io_bus.op_b[i*WIDTH +: WIDTH];
                w_opt       = io_bus.op_t[i];
                w_win_oh[i] = 1'b1;
            end
            if (PW'(i) == r_owner) w_own_oh[i] = 1'b1;
        end
    end

    assign w_res_t = io_bus.mul_product_t | r_mul_op_t
                   | r_gnt_t | io_bus.mul_productDone_t;

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_wd_nxt       = r_wd;
        w_gnt_nxt      = '0;
        w_gnt_t_nxt    = r_gnt_t;
        w_done_nxt     = '0;
        w_done_t_nxt   = 1'b0;
        w_result_nxt   = r_result;
        w_result_t_nxt = r_result_t;
        w_err_nxt      = 1'b0;
        w_err_t_nxt    = 1'b0;
        w_start_nxt    = 1'b0;
        w_start_t_nxt  = 1'b0;
        w_mul_a_nxt    = r_mul_a;
        w_mul_b_nxt    = r_mul_b;
        w_mul_op_t_nxt = r_mul_op_t;
        unique case (r_state)
            S_IDLE: begin
                if (|io_bus.req) begin
                    w_state_nxt    = S_ISSUE;
                    w_owner_nxt    = w_win;
                    w_gnt_nxt      = w_win_oh;
                    w_gnt_t_nxt    = |io_bus.req_t;
                    w_mul_a_nxt    = w_a;
                    w_mul_b_nxt    = w_b;
                    w_mul_op_t_nxt = w_opt;
                end
            end
            S_ISSUE: begin
                w_start_nxt   = 1'b1;
                w_start_t_nxt = r_gnt_t;
                w_wd_nxt      = '0;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                w_wd_nxt = r_wd + WDW'(1);
                if (io_bus.mul_productDone) begin
                    w_result_nxt   = io_bus.mul_product;
                    w_result_t_nxt = w_res_t;
                    w_done_nxt     = w_own_oh;
                    w_done_t_nxt   = w_res_t;
                    w_state_nxt    = S_DELIVER;
                end else if (r_wd == WDW'(TIMEOUT-1)) begin
                    w_err_nxt      = 1'b1;
                    w_err_t_nxt    = r_gnt_t | io_bus.mul_productDone_t;
                    w_ptr_nxt      = r_owner;
                    w_gnt_t_nxt    = 1'b0;
                    w_mul_op_t_nxt = 1'b0;
                    w_result_t_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            S_DELIVER: begin
                w_ptr_nxt      = r_owner;
                w_gnt_t_nxt    = 1'b0;
                w_mul_op_t_nxt = 1'b0;
                w_result_t_nxt = 1'b0;
                w_state_nxt    = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= PW'(NREQ-1);
            r_owner    <= '0;
            r_wd       <= '0;
            r_gnt      <= '0;
            r_gnt_t    <= 1'b0;
            r_done     <= '0;
            r_done_t   <= 1'b0;
            r_result   <= '0;
            r_result_t <= 1'b0;
            r_err      <= 1'b0;
            r_err_t    <= 1'b0;
            r_start    <= 1'b0;
            r_start_t  <= 1'b0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_mul_op_t <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_wd       <= w_wd_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_t    <= w_gnt_t_nxt;
            r_done     <= w_done_nxt;
            r_done_t   <= w_done_t_nxt;
            r_result   <= w_result_nxt;
            r_result_t <= w_result_t_nxt;
            r_err      <= w_err_nxt;
            r_err_t    <= w_err_t_nxt;
            r_start    <= w_start_nxt;
            r_start_t  <= w_start_t_nxt;
            r_mul_a    <= w_mul_a_nxt;
            r_mul_b    <= w_mul_b_nxt;
            r_mul_op_t <= w_mul_op_t_nxt;
        end
    end

    assign io_bus.gnt         = r_gnt;
    assign io_bus.gnt_t       = r_gnt_t;
    assign io_bus.done        = r_done;
    assign io_bus.done_t      = r_done_t;
    assign io_bus.result      = r_result;
    assign io_bus.result_t    = r_result_t;
    assign io_bus.err         = r_err;
    assign io_bus.err_t       = r_err_t;
    assign io_bus.mul_start   = r_start;
    assign io_bus.mul_start_t = r_start_t;
    assign io_bus.mul_a       = r_mul_a;
    assign io_bus.mul_b       = r_mul_b;
    assign io_bus.mul_op_t    = r_mul_op_t;
endmodule

// File: tb/tb_multiplier_share_arbiter.sv
// Scoreboard bench for multiplier_share_arbiter: directed requests,
// a fixed-latency multiplier model and a negedge monitor.
module tb_multiplier_share_arbiter;
    localparam int W    = 4;
    localparam int N    = 2;
    localparam int TO   = 2*W+6;
    localparam int MLAT = 2*W+2;

    typedef struct {
        logic [1:0] oh;
        logic [3:0] a;
        logic [3:0] b;
        logic       gt;
        logic       ot;
    } gexp_t;

    typedef struct {
        logic [1:0] oh;
        logic [7:0] r;
        logic       rt;
    } dexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplier_share_arbiter_if #(.WIDTH(W), .NREQ(N)) bus();

    multiplier_share_arbiter #(
        .WIDTH(W), .NREQ(N), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );

    gexp_t gq[$];
    dexp_t dq[$];
    int n_chk = 0;
    int n_fail = 0;
    int gnt_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_exp_cnt = 0;
    bit mdl_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.gnt, bus.gnt_t, bus.done, bus.done_t,
                    bus.result, bus.result_t, bus.err, bus.err_t,
                    bus.mul_start, bus.mul_start_t,
                    bus.mul_a, bus.mul_b, bus.mul_op_t});
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_g(input logic [1:0] oh, input logic [3:0] a,
                          input logic [3:0] b, input logic gt,
                          input logic ot);
        gexp_t e;
        e.oh = oh; e.a = a; e.b = b; e.gt = gt; e.ot = ot;
        gq.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] oh, input logic [7:0] r,
                          input logic rt);
        dexp_t e;
        e.oh = oh; e.r = r; e.rt = rt;
        dq.push_back(e);
    endtask

    task automatic wait_gnt(input int target);
        for (int c = 0; c < 100 && gnt_cnt < target; c++) step();
        chk("gnt_wait", 32'(gnt_cnt >= target), 32'd1);
    endtask

    task automatic wait_done(input int target);
        for (int c = 0; c < 100 && done_cnt < target; c++) step();
        chk("done_wait", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Single-requester transaction: expected product computed here.
    task automatic run1(input int who, input logic [3:0] a,
                        input logic [3:0] b, input logic ot,
                        input logic rt);
        int gb;
        int db;
        logic [1:0] oh;
        logic [7:0] p;
        oh = (who == 0) ? 2'b01 : 2'b10;
        p  = {4'd0, a} * {4'd0, b};
        gb = gnt_cnt;
        db = done_cnt;
        if (who == 0) begin
            bus.op_a[3:0] = a; bus.op_b[3:0] = b;
        end else begin
            bus.op_a[7:4] = a; bus.op_b[7:4] = b;
        end
        bus.op_t  = ot ? oh : 2'b00;
        bus.req_t = rt ? oh : 2'b00;
        push_g(oh, a, b, rt, ot);
        push_d(oh, p, rt | ot | bus.mul_product_t);
        bus.req = oh;
        wait_gnt(gb + 1);
        bus.req   = 2'b00;
        bus.req_t = 2'b00;
        wait_done(db + 1);
    endtask

    // Multiplier model: productDone MLAT cycles after mul_start.
    initial begin
        int cnt;
        cnt = 0;
        bus.mul_productDone = 1'b0;
        bus.mul_product     = '0;
        forever begin
            @(negedge clk);
            #2;
            bus.mul_productDone = 1'b0;
            if (rst) begin
                cnt = 0;
            end else if (bus.mul_start && mdl_en) begin
                cnt = MLAT;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mul_productDone = 1'b1;
                    bus.mul_product = {4'd0, bus.mul_a} * {4'd0, bus.mul_b};
                end
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents an output.
    initial begin
        gexp_t cur;
        gexp_t g;
        dexp_t d;
        bit busy;
        busy = 1'b0;
        cur = '{oh: 2'b00, a: 4'd0, b: 4'd0, gt: 1'b0, ot: 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
            end else begin
                if (bus.gnt != 2'b00) begin
                    chk("gnt_while_busy", 32'(busy), 32'd0);
                    if (gq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL gnt_unexpected: got gnt=%b required none",
                                 bus.gnt);
                    end else begin
                        g = gq.pop_front();
                        chk("gnt", 32'(bus.gnt), 32'(g.oh));
                        chk("gnt_t", 32'(bus.gnt_t), 32'(g.gt));
                        cur = g;
                    end
                    busy = 1'b1;
                    gnt_cnt++;
                end
                if (bus.mul_start) begin
                    chk("mul_a", 32'(bus.mul_a), 32'(cur.a));
                    chk("mul_b", 32'(bus.mul_b), 32'(cur.b));
                    chk("mul_op_t", 32'(bus.mul_op_t), 32'(cur.ot));
                    chk("mul_start_t", 32'(bus.mul_start_t), 32'(cur.gt));
                end
                if (bus.done != 2'b00) begin
                    chk("done_after_pd", 32'(bus.mul_productDone), 32'd1);
                    if (dq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL done_unexpected: got done=%b required none",
                                 bus.done);
                    end else begin
                        d = dq.pop_front();
                        chk("done", 32'(bus.done), 32'(d.oh));
                        chk("result", 32'(bus.result), 32'(d.r));
                        chk("result_t", 32'(bus.result_t), 32'(d.rt));
                        chk("done_t", 32'(bus.done_t), 32'(d.rt));
                    end
                    busy = 1'b0;
                    done_cnt++;
                end
                if (bus.err) begin
                    chk("err_expected", 32'(err_cnt < err_exp_cnt), 32'd1);
                    busy = 1'b0;
                    err_cnt++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int gb;
        int db;
        int k;
        bus.req               = '0;
        bus.req_t             = '0;
        bus.op_a              = '0;
        bus.op_b              = '0;
        bus.op_t              = '0;
        bus.mul_productDone_t = 1'b0;
        bus.mul_product_t     = 1'b0;

        do_reset();
        chk("reset_outputs", outs(), 32'd0);

        // 1: single request, 3*5
        bus.op_a[3:0] = 4'd3;
        bus.op_b[3:0] = 4'd5;
        push_g(2'b01, 4'd3, 4'd5, 1'b0, 1'b0);
        push_d(2'b01, 8'd15, 1'b0);
        db = done_cnt;
        bus.req = 2'b01;
        step();
        chk("t1_gnt_latency", 32'(bus.gnt), 32'd1);
        bus.req = 2'b00;
        step();
        chk("t1_start_latency", 32'(bus.mul_start), 32'd1);
        wait_done(db + 1);

        // 2: both held, strict alternation 0,1,0,1
        do_reset();
        bus.op_a = {4'd4, 4'd2};
        bus.op_b = {4'd4, 4'd3};
        push_g(2'b01, 4'd2, 4'd3, 1'b0, 1'b0);
        push_g(2'b10, 4'd4, 4'd4, 1'b0, 1'b0);
        push_g(2'b01, 4'd2, 4'd3, 1'b0, 1'b0);
        push_g(2'b10, 4'd4, 4'd4, 1'b0, 1'b0);
        push_d(2'b01, 8'd6, 1'b0);
        push_d(2'b10, 8'd16, 1'b0);
        push_d(2'b01, 8'd6, 1'b0);
        push_d(2'b10, 8'd16, 1'b0);
        gb = gnt_cnt;
        db = done_cnt;
        bus.req = 2'b11;
        wait_gnt(gb + 4);
        bus.req = 2'b00;
        wait_done(db + 4);

        // 3: taint propagation
        run1(1, 4'd7, 4'd6, 1'b1, 1'b0);
        run1(1, 4'd2, 4'd5, 1'b0, 1'b0);
        run1(0, 4'd3, 4'd4, 1'b0, 1'b1);

        // 4: multiplier never completes
        mdl_en = 1'b0;
        err_exp_cnt++;
        bus.op_a[3:0] = 4'd3;
        bus.op_b[3:0] = 4'd3;
        push_g(2'b01, 4'd3, 4'd3, 1'b0, 1'b0);
        gb = gnt_cnt;
        bus.req = 2'b01;
        wait_gnt(gb + 1);
        bus.req = 2'b00;
        for (int c = 0; c < 10 && !bus.mul_start; c++) step();
        chk("t4_start_seen", 32'(bus.mul_start), 32'd1);
        k = 0;
        while (k < 40 && !bus.err) begin
            step();
            k++;
        end
        chk("t4_err_timing", 32'(k), 32'(TO));
        chk("t4_err_t", 32'(bus.err_t), 32'd0);
        chk("t4_no_done", 32'(bus.done), 32'd0);
        mdl_en = 1'b1;
        run1(1, 4'd5, 4'd5, 1'b0, 1'b0);

        // 5: reset in WAIT clears outputs without a clock edge
        bus.op_a[3:0] = 4'd1;
        bus.op_b[3:0] = 4'd1;
        push_g(2'b01, 4'd1, 4'd1, 1'b0, 1'b0);
        gb = gnt_cnt;
        bus.req = 2'b01;
        wait_gnt(gb + 1);
        bus.req = 2'b00;
        step();
        step();
        chk("t5_result_before", 32'(bus.result), 32'd25);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_reset", outs(), 32'd0);
        step();
        step();
        rst = 1'b0;
        bus.op_a = {4'd3, 4'd2};
        bus.op_b = {4'd3, 4'd7};
        push_g(2'b01, 4'd2, 4'd7, 1'b0, 1'b0);
        push_g(2'b10, 4'd3, 4'd3, 1'b0, 1'b0);
        push_d(2'b01, 8'd14, 1'b0);
        push_d(2'b10, 8'd9, 1'b0);
        gb = gnt_cnt;
        db = done_cnt;
        bus.req = 2'b11;
        wait_gnt(gb + 2);
        bus.req = 2'b00;
        wait_done(db + 2);

        // 6: full-scale operands
        run1(0, 4'd15, 4'd15, 1'b0, 1'b0);

        step();
        step();
        chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        chk("err_count", 32'(err_cnt), 32'(err_exp_cnt));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
